// File: rtl/pcileech_com_tx_arb_pkg.sv
// Types and helpers shared by the COM transmit arbiter, its skid buffer and its interface.
package pcileech_com_arb_pkg;

   localparam int COM_WORD_W = 256;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   // Ceiling log2, never below 1 so that a field for a single value keeps one bit.
   function automatic int clog2(input int value);
      int res;
      res = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pcileech_com_tx_arb_if.sv
// Source-side beat handshakes and the COM transmit write port, bundled for the arbiter.
interface pcileech_com_tx_arb_if #(
   parameter int NUM_SRC = 3,
   parameter int WORD_W  = 256
);
   logic [NUM_SRC*WORD_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_last;
   logic [NUM_SRC-1:0]        src_ready;
   logic [WORD_W-1:0]         com_din;
   logic                      com_din_wr_en;
   logic                      com_din_ready;

   modport master (
      output src_data, src_valid, src_last, com_din_ready,
      input  src_ready, com_din, com_din_wr_en
   );

   modport slave (
      input  src_data, src_valid, src_last, com_din_ready,
      output src_ready, com_din, com_din_wr_en
   );
endinterface

// File: rtl/pcileech_com_skid2_chk.sv
// Protocol checker for the 2-entry skid buffer: a push must never meet a full buffer.
module pcileech_com_skid2_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full
);
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/pcileech_com_tx_arb_skid2.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is the head and is driven out directly.
module pcileech_com_skid2 #(
   parameter int WORD_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic [WORD_W-1:0] dout,
   output logic [1:0]        count_nxt,
   output logic              empty
);
   logic [WORD_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              full_s, pop_s;

   assign empty  = (cnt_q == 2'd0);
   assign full_s = (cnt_q == 2'd2);
   assign pop_s  = pop & ~empty;
   assign dout   = empty ? {WORD_W{1'b0}} : ent0_q;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({push, pop_s})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = din;
            else               ent1_d = din;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push/pop: the new word lands behind whatever survives the pop.
            if (cnt_q == 2'd1) begin
               ent0_d = din;
            end else begin
               ent0_d = ent1_q;
               ent1_d = din;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   assign count_nxt = cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_q <= {WORD_W{1'b0}};
         ent1_q <= {WORD_W{1'b0}};
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   pcileech_com_skid2_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .full (full_s)
   );
endmodule

// File: rtl/pcileech_com_tx_arb.sv
// Packet-granular round-robin arbiter sharing the COM transmit write port between NUM_SRC sources.
module pcileech_com_tx_arb
   import pcileech_com_arb_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int WORD_W    = COM_WORD_W,
   parameter int MAX_BEATS = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   pcileech_com_tx_arb_if.slave        bus,
   output logic [clog2(NUM_SRC)-1:0]   grant_id,
   output logic                        busy,
   output logic                        err_overrun,
   input  logic                        err_clr
);
   localparam int GID_W = clog2(NUM_SRC);
   localparam int CNT_W = clog2(MAX_BEATS + 1);

   arb_state_e         state_q, state_d;
   logic [GID_W-1:0]   grant_q, grant_d, rr_q, rr_d, winner_s;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [NUM_SRC-1:0] src_ready_q, src_ready_d;
   logic               busy_q, busy_d, err_q, err_d;
   logic               any_valid_s, accept_s, wr_en_s, empty_s;
   logic [1:0]         count_nxt_s;
   logic [WORD_W-1:0]  beat_s;

   // First valid source cyclically after the last winner; descending scan lets the nearest win.
   always_comb begin
      winner_s    = rr_q;
      any_valid_s = 1'b0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         if (bus.src_valid[(int'(rr_q) + k) % NUM_SRC]) begin
            winner_s    = GID_W'((int'(rr_q) + k) % NUM_SRC);
            any_valid_s = 1'b1;
         end
      end
   end

   assign accept_s = (state_q == ARB_LOCK) & bus.src_valid[grant_q] & src_ready_q[grant_q];
   assign beat_s   = bus.src_data[int'(grant_q)*WORD_W +: WORD_W];
   assign wr_en_s  = ~empty_s & bus.com_din_ready;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_clr ? 1'b0 : err_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_valid_s) begin
               grant_d    = winner_s;
               rr_d       = winner_s;
               beat_cnt_d = {CNT_W{1'b0}};
               state_d    = ARB_LOCK;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_LOCK: begin
            if (accept_s) begin
               if (bus.src_last[grant_q]) begin
                  state_d    = ARB_IDLE;
                  beat_cnt_d = {CNT_W{1'b0}};
               end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                  // Forced release; a new overrun beats a same-cycle clear.
                  state_d    = ARB_IDLE;
                  beat_cnt_d = {CNT_W{1'b0}};
                  err_d      = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ARB_LOCK;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      src_ready_d = {NUM_SRC{1'b0}};
      if ((state_d == ARB_LOCK) && (count_nxt_s < 2'd2)) begin
         src_ready_d[grant_d] = 1'b1;
      end else begin
         src_ready_d = {NUM_SRC{1'b0}};
      end
      busy_d = (state_d == ARB_LOCK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         grant_q     <= {GID_W{1'b0}};
         rr_q        <= GID_W'(NUM_SRC - 1);
         beat_cnt_q  <= {CNT_W{1'b0}};
         src_ready_q <= {NUM_SRC{1'b0}};
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         beat_cnt_q  <= beat_cnt_d;
         src_ready_q <= src_ready_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   pcileech_com_skid2 #(.WORD_W(WORD_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (accept_s),
      .din       (beat_s),
      .pop       (wr_en_s),
      .dout      (bus.com_din),
      .count_nxt (count_nxt_s),
      .empty     (empty_s)
   );

   assign bus.com_din_wr_en = wr_en_s;
   assign bus.src_ready     = src_ready_q;
   assign grant_id          = grant_q;
   assign busy              = busy_q;
   assign err_overrun       = err_q;
endmodule

// File: tb/tb_pcileech_com_tx_arb.sv
// Randomized scoreboard bench for pcileech_com_tx_arb with a packet-level reference model.
module tb_pcileech_com_tx_arb;
   import pcileech_com_arb_pkg::*;

   localparam int NS = 3;
   localparam int W  = 256;
   localparam int MB = 4;

   typedef struct {
      logic [W-1:0] d;
      logic         last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       err_clr = 1'b0;
   logic [1:0] grant_id;
   logic       busy, err_overrun;

   pcileech_com_tx_arb_if #(.NUM_SRC(NS), .WORD_W(W)) bus ();

   pcileech_com_tx_arb #(.NUM_SRC(NS), .WORD_W(W), .MAX_BEATS(MB)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_overrun (err_overrun),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   beat_t        sq [NS][$];   // pending beats per source, front is what is driven
   logic [W-1:0] exp_q[$];     // words expected on com_din, in order
   int n_vec = 0;
   int n_err = 0;

   // reference model: grant owner, rr pointer, beats in this grant, words buffered, error flag
   bit m_lock;
   int m_gnt, m_rr, m_beats, m_cnt;
   bit m_err;

   int gap_pct = 0, rdy_pct = 100, clr_pct = 0;
   bit rdy_low = 1'b0, clr_hold = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int k = 0; k < W/32; k++) w[k*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic push_pkt(input int s, input int len, input bit with_last);
      beat_t x;
      for (int b = 0; b < len; b++) begin
         x.d    = rand_word();
         x.last = with_last && (b == len - 1);
         sq[s].push_back(x);
      end
   endtask

   task automatic model_reset();
      m_lock = 1'b0; m_gnt = 0; m_rr = NS - 1; m_beats = 0; m_cnt = 0; m_err = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NS; i++) sq[i].delete();
   endtask

   // Apply the arbitration rules to what was presented in the cycle ending at this edge.
   task automatic model_step();
      logic [NS-1:0] v;
      bit pop, acc, set;
      int win, c;
      beat_t b;
      v   = bus.src_valid;
      pop = (m_cnt > 0) && bus.com_din_ready;
      acc = 1'b0;
      set = 1'b0;
      if (!m_lock) begin
         if (v != '0) begin
            win = -1;
            for (int k = 1; k <= NS; k++) begin
               c = (m_rr + k) % NS;
               if (win < 0 && v[c]) win = c;
            end
            m_gnt = win; m_rr = win; m_lock = 1'b1; m_beats = 0;
         end
      end else if (v[m_gnt] && m_cnt < 2) begin
         b = sq[m_gnt].pop_front();
         exp_q.push_back(b.d);
         acc = 1'b1;
         m_beats++;
         if (b.last) m_lock = 1'b0;
         else if (m_beats == MB) begin
            m_lock = 1'b0;
            set    = 1'b1;
         end
      end
      if (set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_cnt = m_cnt + int'(acc) - int'(pop);
   endtask

   task automatic check_regs();
      logic [NS-1:0] er;
      er = '0;
      if (m_lock && m_cnt < 2) er[m_gnt] = 1'b1;
      chk("src_ready", W'(bus.src_ready), W'(er));
      chk("busy", W'(busy), W'(m_lock));
      chk("grant_id", W'(grant_id), W'(m_gnt));
      chk("err_overrun", W'(err_overrun), W'(m_err));
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (sq[i].size() > 0) begin
            bus.src_valid[i]       = ($urandom_range(99) >= gap_pct);
            bus.src_data[i*W +: W] = sq[i][0].d;
            bus.src_last[i]        = sq[i][0].last;
         end else begin
            bus.src_valid[i]       = 1'b0;
            bus.src_data[i*W +: W] = '0;
            bus.src_last[i]        = 1'b0;
         end
      end
      bus.com_din_ready = rdy_low ? 1'b0 : ($urandom_range(99) < rdy_pct);
      err_clr = clr_hold || ($urandom_range(99) < clr_pct);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_regs();
      drive();
   endtask

   function automatic bit pending();
      bit p;
      p = m_lock || (m_cnt > 0);
      for (int i = 0; i < NS; i++) if (sq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input int maxc);
      int c;
      c = 0;
      while (pending() && c < maxc) begin
         cycle();
         c++;
      end
      n_vec++;
      if (c >= maxc) begin
         n_err++;
         $display("FAIL drain: still busy after %0d cycles, required idle", c);
      end
      cycle();
      cycle();
   endtask

   // Output monitor: every write must match the scoreboard head, and nothing may be written when it is empty.
   always @(negedge clk) begin
      logic exp_wr;
      if (!rst) begin
         exp_wr = (exp_q.size() > 0) && bus.com_din_ready;
         chk("com_din_wr_en", W'(bus.com_din_wr_en), W'(exp_wr));
         if (exp_q.size() > 0) begin
            if (bus.com_din_wr_en) chk("com_din", bus.com_din, exp_q.pop_front());
            else                   chk("com_din_hold", bus.com_din, exp_q[0]);
         end else begin
            chk("com_din_empty", bus.com_din, '0);
         end
      end
   end

   initial begin
      bus.src_valid = '0; bus.src_last = '0; bus.src_data = '0; bus.com_din_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_regs();
      drive();

      // single source, 3-beat packet
      push_pkt(1, 3, 1'b1);
      drain(100);

      // three sources with 2-beat packets, then src0 and src1 together
      for (int s = 0; s < NS; s++) push_pkt(s, 2, 1'b1);
      drain(100);
      push_pkt(1, 2, 1'b1);
      push_pkt(0, 2, 1'b1);
      drain(100);

      // backpressure: COM not ready for 5 cycles mid-packet
      push_pkt(0, 8, 1'b1);
      repeat (4) cycle();
      rdy_low = 1'b1;
      repeat (5) cycle();
      rdy_low = 1'b0;
      drain(200);

      // overrun, clear, then clear held across a second overrun
      push_pkt(2, 6, 1'b1);
      drain(100);
      clr_hold = 1'b1;
      repeat (2) cycle();
      clr_hold = 1'b0;
      cycle();
      push_pkt(2, 4, 1'b1);
      push_pkt(2, 4, 1'b0);
      drain(100);
      clr_hold = 1'b1;
      push_pkt(2, 4, 1'b0);
      drain(100);
      clr_hold = 1'b0;
      cycle();

      // asynchronous reset mid-packet
      push_pkt(1, 4, 1'b1);
      repeat (3) cycle();
      #2 rst = 1'b1;
      #1;
      chk("rst_wr_en", W'(bus.com_din_wr_en), W'(0));
      chk("rst_src_ready", W'(bus.src_ready), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_regs();
      push_pkt(1, 2, 1'b1);
      push_pkt(0, 2, 1'b1);
      drain(100);

      // back-to-back single-beat packets from one source
      for (int p = 0; p < 4; p++) push_pkt(0, 1, 1'b1);
      drain(100);

      // randomized traffic with gaps, backpressure and clears
      gap_pct = 25; rdy_pct = 70; clr_pct = 10;
      for (int batch = 0; batch < 4; batch++) begin
         for (int p = 0; p < 16; p++) begin
            push_pkt($urandom_range(NS - 1), $urandom_range(6, 1), 1'b1);
         end
         drain(3000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
